// File: rtl/jtag_master.sv
// jtag_master: command/response JTAG TAP driver.
// One command at a time: TAP reset, IR scan, DR scan (1..16 bits) or idle clocks.
// TCK is divided down from CLK by CLK_DIV per half-period; all outputs are registered.
// Compile option JTAG_MASTER_IDLE_EN: when defined, the idle command emits TCK
// periods with TMS=0; when undefined it completes without any TCK activity.
module jtag_master #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [3:0]  cmd_len,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        TCK,
    output logic        TMS,
    output logic        TDI,
    input  logic        TDO
);

    localparam int unsigned DIV_W    = 8;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned DATA_W   = 16;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(5);

    localparam logic [1:0] CMD_RESET = 2'b00;
    localparam logic [1:0] CMD_IR    = 2'b01;
    localparam logic [1:0] CMD_DR    = 2'b10;
    localparam logic [1:0] CMD_IDLE  = 2'b11;

    // Each active state names the TAP state the target occupies during that TCK period.
    typedef enum logic [3:0] {
        IDLE,
        RESET,
        SEL_DR,
        SEL_IR,
        CAPTURE,
        SHIFT,
        EXIT,
        UPDATE,
        RTI,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                high_q, high_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          type_q, type_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   rsp_q, rsp_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                tck_q, tck_d;
    logic                tms_q, tms_d;
    logic                tdi_q, tdi_d;
    logic                load;

    // TMS value driven for the whole period spent in a given state.
    function automatic logic tms_of(input state_e s, input logic [CNT_W-1:0] cnt,
                                    input logic [1:0] typ, input logic [CNT_W-1:0] len);
        logic v;
        v = 1'b0;
        case (s)
            RESET:   v = (cnt != RESET_LAST);
            RTI:     v = (typ != CMD_IDLE);
            SEL_DR:  v = (typ == CMD_IR);
            SHIFT:   v = (cnt == len);
            EXIT:    v = 1'b1;
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    // State register and datapath flops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            div_q       <= '0;
            high_q      <= 1'b0;
            cnt_q       <= '0;
            type_q      <= CMD_RESET;
            len_q       <= '0;
            data_q      <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            high_q      <= high_d;
            cnt_q       <= cnt_d;
            type_q      <= type_d;
            len_q       <= len_d;
            data_q      <= data_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
        end
    end

    // Next-state: command accept, TCK phase timing, per-period state stepping.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        high_d      = high_q;
        cnt_d       = cnt_q;
        type_d      = type_q;
        len_d       = len_q;
        data_d      = data_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    type_d = cmd_type;
                    len_d  = cmd_len;
                    data_d = cmd_data;
                    rsp_d  = '0;
                    cnt_d  = '0;
                    div_d  = '0;
                    high_d = 1'b0;
                    case (cmd_type)
                        CMD_RESET: state_d = RESET;
                        CMD_IR:    state_d = RTI;
                        CMD_DR:    state_d = RTI;
                        default: begin
`ifdef JTAG_MASTER_IDLE_EN
                            state_d = RTI;
`else
                            state_d = DONE;
`endif
                        end
                    endcase
                    load = (state_d != DONE);
                end
            end
            DONE: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else if (!high_q) begin
                    // Low phase over: raise TCK and capture TDO on shift periods.
                    div_d  = '0;
                    high_d = 1'b1;
                    tck_d  = 1'b1;
                    if (state_q == SHIFT) begin
                        rsp_d[cnt_q] = TDO;
                    end
                end else begin
                    // High phase over: drop TCK and step to the next period.
                    div_d  = '0;
                    high_d = 1'b0;
                    tck_d  = 1'b0;
                    case (state_q)
                        RESET: begin
                            if (cnt_q == RESET_LAST) state_d = DONE;
                            else cnt_d = cnt_q + CNT_W'(1);
                        end
                        RTI: begin
`ifdef JTAG_MASTER_IDLE_EN
                            if (type_q == CMD_IDLE) begin
                                if (cnt_q == len_q) state_d = DONE;
                                else cnt_d = cnt_q + CNT_W'(1);
                            end else begin
                                state_d = SEL_DR;
                            end
`else
                            state_d = SEL_DR;
`endif
                        end
                        SEL_DR:  state_d = (type_q == CMD_IR) ? SEL_IR : CAPTURE;
                        SEL_IR:  state_d = CAPTURE;
                        CAPTURE: begin
                            state_d = SHIFT;
                            cnt_d   = '0;
                        end
                        SHIFT: begin
                            if (cnt_q == len_q) state_d = EXIT;
                            else cnt_d = cnt_q + CNT_W'(1);
                        end
                        EXIT:    state_d = UPDATE;
                        default: state_d = DONE;
                    endcase
                    if (state_d == DONE) begin
                        rsp_valid_d = 1'b1;
                        tdi_d       = 1'b0;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
        endcase

        if (load) begin
            tms_d = tms_of(state_d, cnt_d, type_d, len_d);
            tdi_d = (state_d == SHIFT) ? data_d[cnt_d] : 1'b0;
        end

        cmd_ready_d = (state_d == IDLE) && !rsp_valid_d;
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_q;
    assign TCK       = tck_q;
    assign TMS       = tms_q;
    assign TDI       = tdi_q;

endmodule

// File: tb/tb_jtag_master.sv
// tb_jtag_master: directed + random command bench with a period-level reference model.
module tb_jtag_master;

    localparam int unsigned CLK_DIV = 2;

    logic        CLK;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [3:0]  cmd_len;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        TCK;
    logic        TMS;
    logic        TDI;
    logic        TDO;

    int   tdo_mode;   // 0: TDO looped from TDI, 1: tied high, 2: random per period
    logic tdo_r;

    int n_assert;
    int n_fail;

    bit exp_tms_q[$];
    bit exp_tdi_q[$];
    bit tms_obs[$];
    bit tdi_obs[$];
    bit tdo_obs[$];

    assign TDO = (tdo_mode == 0) ? TDI : tdo_r;

    jtag_master #(.CLK_DIV(CLK_DIV)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .TCK       (TCK),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: per-TCK-period TMS/TDI lists straight from the command rules.
    task automatic build_exp(input logic [1:0] t, input int n, input logic [15:0] d, output int pre);
        exp_tms_q.delete();
        exp_tdi_q.delete();
        pre = 0;
        case (t)
            2'b00: begin
                for (int k = 0; k < 6; k++) begin
                    exp_tms_q.push_back(k < 5);
                    exp_tdi_q.push_back(1'b0);
                end
            end
            2'b01, 2'b10: begin
                exp_tms_q.push_back(1'b1);
                if (t == 2'b01) exp_tms_q.push_back(1'b1);
                exp_tms_q.push_back(1'b0);
                exp_tms_q.push_back(1'b0);
                pre = exp_tms_q.size();
                for (int k = 0; k < pre; k++) exp_tdi_q.push_back(1'b0);
                for (int i = 0; i < n; i++) begin
                    exp_tms_q.push_back(i == n - 1);
                    exp_tdi_q.push_back(d[i]);
                end
                exp_tms_q.push_back(1'b1);
                exp_tms_q.push_back(1'b0);
                exp_tdi_q.push_back(1'b0);
                exp_tdi_q.push_back(1'b0);
            end
            default: begin
`ifdef JTAG_MASTER_IDLE_EN
                for (int k = 0; k < n; k++) begin
                    exp_tms_q.push_back(1'b0);
                    exp_tdi_q.push_back(1'b0);
                end
`endif
            end
        endcase
    endtask

    // Issue one command, monitor the JTAG pins until the response, then check and consume it.
    task automatic run_cmd(input string name, input logic [1:0] t, input logic [3:0] len,
                           input logic [15:0] d, input int mode, input int hold,
                           input logic [1:0] t2, input logic [3:0] l2, input logic [15:0] d2);
        int n, pre, waitc, cyc, run, viol, hviol, p, exp_lat;
        logic prev_tck, prev_tms, prev_tdi;
        logic [31:0] v_obs, v_exp, mask;
        logic [15:0] exp_rsp;

        n = int'(len) + 1;
        build_exp(t, n, d, pre);
        waitc = 0;
        while (cmd_ready !== 1'b1 && waitc < 100) begin
            @(negedge CLK);
            waitc++;
        end
        check({name, "_ready_wait"}, 32'(waitc < 100), 32'd1);

        tdo_mode  = mode;
        tdo_r     = (mode == 1) ? 1'b1 : 1'($urandom % 2);
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_len   = len;
        cmd_data  = d;
        prev_tms  = TMS;
        prev_tdi  = TDI;
        @(negedge CLK);
        cmd_valid = 1'b0;
        cmd_type  = 2'($urandom);
        cmd_len   = 4'($urandom);
        cmd_data  = 16'($urandom);

        tms_obs.delete();
        tdi_obs.delete();
        tdo_obs.delete();
        prev_tck = 1'b0;
        run  = 0;
        viol = 0;
        cyc  = 1;
        while (cyc <= 2000) begin
            if (TCK === prev_tck) run++;
            else begin
                if (run != int'(CLK_DIV)) viol++;
                run = 1;
            end
            if (cyc != 1 && !(prev_tck == 1'b1 && TCK == 1'b0)) begin
                if (TMS !== prev_tms) viol++;
                if (TDI !== prev_tdi) viol++;
            end
            if (prev_tck == 1'b0 && TCK == 1'b1) begin
                tms_obs.push_back(TMS);
                tdi_obs.push_back(TDI);
                tdo_obs.push_back(TDO);
            end
            if (prev_tck == 1'b1 && TCK == 1'b0 && mode == 2) tdo_r = 1'($urandom % 2);
            prev_tck = TCK;
            prev_tms = TMS;
            prev_tdi = TDI;
            if (rsp_valid === 1'b1) break;
            @(negedge CLK);
            cyc++;
        end

        p = exp_tms_q.size();
        exp_lat = (p == 0) ? 2 : p * 2 * int'(CLK_DIV) + 1;
        check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({name, "_periods"}, 32'(tms_obs.size()), 32'(p));
        v_obs = '0;
        v_exp = '0;
        for (int k = 0; k < tms_obs.size() && k < 32; k++) v_obs[k] = tms_obs[k];
        for (int k = 0; k < p && k < 32; k++) v_exp[k] = exp_tms_q[k];
        check({name, "_tms"}, v_obs, v_exp);
        v_obs = '0;
        v_exp = '0;
        for (int k = 0; k < tdi_obs.size() && k < 32; k++) v_obs[k] = tdi_obs[k];
        for (int k = 0; k < exp_tdi_q.size() && k < 32; k++) v_exp[k] = exp_tdi_q[k];
        check({name, "_tdi"}, v_obs, v_exp);
        check({name, "_timing"}, 32'(viol), 32'd0);

        mask = (32'd1 << n) - 32'd1;
        exp_rsp = '0;
        if (t == 2'b01 || t == 2'b10) begin
            if (mode == 0) exp_rsp = 16'(32'(d) & mask);
            else if (mode == 1) exp_rsp = 16'(mask);
            else begin
                for (int i = 0; i < n; i++)
                    if (pre + i < tdo_obs.size()) exp_rsp[i] = tdo_obs[pre + i];
            end
        end
        check({name, "_rsp_data"}, 32'(rsp_data), 32'(exp_rsp));

        hviol = 0;
        if (hold > 0) begin
            cmd_valid = 1'b1;
            cmd_type  = t2;
            cmd_len   = l2;
            cmd_data  = d2;
        end
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            @(negedge CLK);
            if (rsp_valid !== 1'b1 || rsp_data !== exp_rsp || cmd_ready !== 1'b0 || TCK !== 1'b0)
                hviol++;
        end
        if (hold > 0) check({name, "_hold"}, 32'(hviol), 32'd0);

        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        check({name, "_rsp_clear"}, 32'(rsp_valid), 32'd0);
        check({name, "_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int rises, cnt, viol;
        logic prev_tck;
        logic [1:0] rt;

        n_assert  = 0;
        n_fail    = 0;
        RST       = 1'b1;
        cmd_valid = 1'b0;
        cmd_type  = '0;
        cmd_len   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        tdo_mode  = 1;
        tdo_r     = 1'b1;

        // Reset values.
        repeat (3) @(negedge CLK);
        check("rst_tck", 32'(TCK), 32'd0);
        check("rst_tms", 32'(TMS), 32'd1);
        check("rst_tdi", 32'(TDI), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Directed commands.
        run_cmd("tap_reset", 2'b00, 4'd0, 16'h0000, 1, 0, 2'b00, 4'd0, 16'h0);
        run_cmd("dr_loop", 2'b10, 4'd4, 16'h0015, 0, 0, 2'b00, 4'd0, 16'h0);
        run_cmd("ir_tdo1", 2'b01, 4'd3, 16'h000A, 1, 0, 2'b00, 4'd0, 16'h0);
        run_cmd("dr_hold", 2'b10, 4'd7, 16'h5AC3, 2, 10, 2'b00, 4'd0, 16'h0);
        run_cmd("second_cmd", 2'b00, 4'd0, 16'h0000, 1, 0, 2'b00, 4'd0, 16'h0);
        run_cmd("idle_cmd", 2'b11, 4'd2, 16'hFFFF, 1, 0, 2'b00, 4'd0, 16'h0);

        // Abort a 16-bit DR scan while TCK is high in shift bit 2.
        cnt = 0;
        while (cmd_ready !== 1'b1 && cnt < 100) begin
            @(negedge CLK);
            cnt++;
        end
        tdo_mode  = 0;
        cmd_valid = 1'b1;
        cmd_type  = 2'b10;
        cmd_len   = 4'd15;
        cmd_data  = 16'($urandom);
        @(negedge CLK);
        cmd_valid = 1'b0;
        rises = 0;
        cnt = 0;
        prev_tck = 1'b0;
        while (cnt < 500) begin
            if (prev_tck == 1'b0 && TCK == 1'b1) rises++;
            if (rises == 6) break;
            prev_tck = TCK;
            @(negedge CLK);
            cnt++;
        end
        check("abort_reached_shift2", 32'(rises), 32'd6);
        check("abort_tck_high_before", 32'(TCK), 32'd1);
        #1 RST = 1'b1;
        #1;
        check("abort_tck", 32'(TCK), 32'd0);
        check("abort_tms", 32'(TMS), 32'd1);
        check("abort_tdi", 32'(TDI), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (rsp_valid !== 1'b0 || TCK !== 1'b0) viol++;
        end
        check("abort_quiet", 32'(viol), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        run_cmd("post_abort_reset", 2'b00, 4'd0, 16'h0000, 1, 0, 2'b00, 4'd0, 16'h0);

        // Random commands.
        for (int r = 0; r < 12; r++) begin
            rt = 2'($urandom % 4);
            run_cmd($sformatf("rand%0d", r), rt, 4'($urandom % 16), 16'($urandom),
                    int'($urandom % 3), 0, 2'b00, 4'd0, 16'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
